// File: rtl/exc_commit_ctrl.sv
// Writeback commit controller: resolves interrupt > exception > ertn > CSR write,
// drives the CSR write/exception/ertn interface and redirects fetch. Optional trap counter: EXC_COMMIT_CNT_EN.
module exc_commit_ctrl #(
  parameter int                   CSR_NUM_W      = 14,
  parameter logic [CSR_NUM_W-1:0] CSR_EENTRY_NUM = 'h00c,
  parameter logic [CSR_NUM_W-1:0] CSR_ERA_NUM    = 'h006,
  parameter logic [5:0]           ECODE_INT      = 6'h00
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_pc,
  input  logic [31:0]          in_vaddr,
  input  logic                 in_ex,
  input  logic [5:0]           in_ecode,
  input  logic [8:0]           in_esubcode,
  input  logic                 in_ertn,
  input  logic                 in_csr_we,
  input  logic [CSR_NUM_W-1:0] in_csr_num,
  input  logic [31:0]          in_csr_wvalue,
  input  logic [31:0]          in_csr_wmask,
  input  logic                 has_int,
  output logic                 csr_we,
  output logic [CSR_NUM_W-1:0] csr_num,
  output logic [31:0]          csr_wvalue,
  output logic [31:0]          csr_wmask,
  output logic [CSR_NUM_W-1:0] csr_num_r,
  input  logic [31:0]          csr_rvalue,
  output logic                 wb_ex,
  output logic [5:0]           wb_ecode,
  output logic [8:0]           wb_esubcode,
  output logic [31:0]          wb_pc,
  output logic [31:0]          wb_vaddr,
  output logic                 ertn_flush,
  output logic                 pipe_flush,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 retire_valid,
  output logic [31:0]          exc_count
);

  typedef enum logic [1:0] {RUN, RESOLVE, REDIR} state_t;

  state_t                 state_q, state_d;
  logic                   isTrap_q;
  logic                   retire_q;
  logic                   csrWe_q;
  logic [CSR_NUM_W-1:0]   csrNum_q;
  logic [31:0]            csrWvalue_q;
  logic [31:0]            csrWmask_q;
  logic [CSR_NUM_W-1:0]   csrNumR_q;
  logic [5:0]             ecode_q;
  logic [8:0]             esubcode_q;
  logic [31:0]            pc_q;
  logic [31:0]            vaddr_q;
  logic [31:0]            redirPc_q;

  logic accept;
  logic takeTrap;
  logic takeErtn;
  logic takeCsrWe;

  // Interrupts are only considered on an accepted instruction; an exception overrides ertn.
  assign accept    = in_valid & (state_q == RUN);
  assign takeTrap  = accept & (has_int | in_ex);
  assign takeErtn  = accept & ~(has_int | in_ex) & in_ertn;
  assign takeCsrWe = accept & ~(has_int | in_ex) & ~in_ertn & in_csr_we;

  always_comb begin
    state_d        = state_q;
    in_ready       = 1'b0;
    pipe_flush     = 1'b0;
    wb_ex          = 1'b0;
    ertn_flush     = 1'b0;
    redirect_valid = 1'b0;
    case (state_q)
      RUN: begin
        in_ready = 1'b1;
        if (takeTrap || takeErtn) state_d = RESOLVE;
      end
      RESOLVE: begin
        pipe_flush = 1'b1;
        wb_ex      = isTrap_q;
        ertn_flush = ~isTrap_q;
        state_d    = REDIR;
      end
      REDIR: begin
        pipe_flush     = 1'b1;
        redirect_valid = 1'b1;
        state_d        = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      isTrap_q    <= 1'b0;
      retire_q    <= 1'b0;
      csrWe_q     <= 1'b0;
      csrNum_q    <= '0;
      csrWvalue_q <= '0;
      csrWmask_q  <= '0;
      csrNumR_q   <= CSR_EENTRY_NUM;
      ecode_q     <= '0;
      esubcode_q  <= '0;
      pc_q        <= '0;
      vaddr_q     <= '0;
      redirPc_q   <= '0;
    end else begin
      retire_q <= accept & ~(has_int | in_ex);
      csrWe_q  <= takeCsrWe;
      if (takeCsrWe) begin
        csrNum_q    <= in_csr_num;
        csrWvalue_q <= in_csr_wvalue;
        csrWmask_q  <= in_csr_wmask;
      end
      if (takeTrap) begin
        isTrap_q   <= 1'b1;
        csrNumR_q  <= CSR_EENTRY_NUM;
        ecode_q    <= has_int ? ECODE_INT : in_ecode;
        esubcode_q <= has_int ? 9'd0 : in_esubcode;
        pc_q       <= in_pc;
        vaddr_q    <= in_vaddr;
      end else if (takeErtn) begin
        isTrap_q  <= 1'b0;
        csrNumR_q <= CSR_ERA_NUM;
      end
      // The CSR read port is pointed at the target during RESOLVE; capture it for REDIR.
      if (state_q == RESOLVE) redirPc_q <= csr_rvalue;
    end
  end

  assign retire_valid = retire_q;
  assign csr_we       = csrWe_q;
  assign csr_num      = csrNum_q;
  assign csr_wvalue   = csrWvalue_q;
  assign csr_wmask    = csrWmask_q;
  assign csr_num_r    = csrNumR_q;
  assign wb_ecode     = ecode_q;
  assign wb_esubcode  = esubcode_q;
  assign wb_pc        = pc_q;
  assign wb_vaddr     = vaddr_q;
  assign redirect_pc  = redirPc_q;

`ifdef EXC_COMMIT_CNT_EN
  logic [31:0] excCount_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            excCount_q <= '0;
    else if (wb_ex && excCount_q != '1)   excCount_q <= excCount_q + 32'd1;
  end

  assign exc_count = excCount_q;
`else
  assign exc_count = '0;
`endif

endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
- Writeback-stage commit controller; the initiator/driver side of the CSR block's write, exception and ertn interface.
- Accepts one instruction per cycle from MEM and resolves priority: interrupt > exception > ertn > CSR write.
- Drives the CSR write port, wb_ex/ertn_flush pulses and exception info.
- On a trap or ertn it reads the redirect target (EENTRY or ERA) through the CSR read port, then flushes the pipeline and redirects fetch.

Parameters:
CSR_NUM_W, 14, CSR number width
CSR_EENTRY_NUM, 14'h00c, EENTRY CSR number
CSR_ERA_NUM, 14'h006, ERA CSR number
ECODE_INT, 6'h00, ecode reported for interrupts

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  MEM->WB instruction valid
in_ready  out  1  WB can accept
in_pc  in  32  instruction PC
in_vaddr  in  32  faulting data address
in_ex  in  1  instruction carries an exception from earlier stages
in_ecode  in  6  its ecode
in_esubcode  in  9  its esubcode
in_ertn  in  1  instruction is ertn
in_csr_we  in  1  instruction writes a CSR
in_csr_num  in  CSR_NUM_W  target CSR
in_csr_wvalue  in  32  write data
in_csr_wmask  in  32  write mask
has_int  in  1  interrupt pending, from the CSR block
csr_we  out  1  CSR write strobe
csr_num  out  CSR_NUM_W  write CSR number
csr_wvalue  out  32  write data
csr_wmask  out  32  write mask
csr_num_r  out  CSR_NUM_W  read CSR number
csr_rvalue  in  32  read data (combinational from the CSR block)
wb_ex  out  1  exception commit pulse
wb_ecode  out  6  committed ecode
wb_esubcode  out  9  committed esubcode
wb_pc  out  32  committed PC
wb_vaddr  out  32  committed vaddr
ertn_flush  out  1  ertn commit pulse
pipe_flush  out  1  kill all younger stages
redirect_valid  out  1  fetch redirect pulse
redirect_pc  out  32  redirect target
retire_valid  out  1  non-trapping instruction retired
exc_count  out  32  trap counter (see Optional Feature)

Behaviour:
- FSM states are RUN, RESOLVE and REDIR. Reset (async) enters RUN.
- Reset values: all pulse outputs 0; csr_num_r = CSR_EENTRY_NUM; data outputs 0; redirect_pc 0.
- in_ready = (state == RUN).
- Accept = in_valid & in_ready at cycle T. The instruction is registered, and outputs appear at T+1.
- Trap classification at T:
  - has_int=1 -> ecode ECODE_INT, esubcode 0.
  - else in_ex=1 -> in_ecode/in_esubcode.
  - in_ex together with in_ertn -> exception wins.
- Trap path:
  - T+1 (RESOLVE): wb_ex=1 for one cycle; wb_pc=in_pc; wb_vaddr=in_vaddr; csr_num_r=EENTRY; redirect_pc <= csr_rvalue at the end of the cycle.
  - T+2 (REDIR): redirect_valid=1 for one cycle.
  - T+3: RUN.
- ertn path: as the trap path, but ertn_flush=1 at T+1 instead of wb_ex, and csr_num_r=ERA. retire_valid=1 at T+1.
- pipe_flush=1 throughout RESOLVE and REDIR (T+1, T+2).
- A trapping instruction never asserts csr_we or retire_valid.
- Plain instruction: retire_valid=1 at T+1. If in_csr_we, csr_we=1 at T+1 with the registered num/wvalue/wmask. Throughput is one per cycle with no bubble.
- has_int is sampled only on accept cycles. It is ignored in RESOLVE/REDIR and when in_valid=0.
- wb_ecode/esubcode/pc/vaddr hold their last committed values when wb_ex=0.
- Reset during RESOLVE/REDIR: immediately returns to RUN; no redirect is issued.

Optional Feature:
- Macro EXC_COMMIT_CNT_EN.
- Defined: exc_count is a 32-bit counter, reset 0. It increments on each wb_ex pulse and saturates at 32'hffffffff. ertn does not count.
- Undefined: exc_count is tied to 0 and the block contains no counter flops.

Test Plan:
- Back-to-back plain instructions, second with in_csr_we num=0x30 wvalue=0xdeadbeef mask=0xffffffff -> retire_valid on consecutive cycles; csr_we pulses once with those values.
- in_ex=1 ecode=0x0b at pc=0x1c000100, csr_rvalue(EENTRY)=0x1c008000 -> wb_ex@T+1, wb_pc=0x1c000100, ecode 0x0b, redirect_valid@T+2 pc=0x1c008000, in_ready low T+1..T+2, no csr_we.
- has_int=1 together with in_ex=1 ecode=0x08 -> wb_ecode=0x00, esubcode 0.
- in_ertn=1 with ERA=0x1c000204 -> ertn_flush@T+1, csr_num_r=ERA, redirect_pc=0x1c000204@T+2, no wb_ex.
- Reset asserted during RESOLVE -> all pulses 0 immediately, in_ready=1 after release, no redirect_valid.
- With EXC_COMMIT_CNT_EN: 3 traps plus 1 ertn -> exc_count=3; preload near saturation -> holds 32'hffffffff.
